uart_comm: RTL and testbench
============================

# uart_comm

Host-side serial endpoint for the oscilloscope digital core. It deserialises 8N1 UART bytes from the host into 24-bit commands, presenting them on the `cmd`/`cmd_rdy`/`clr_cmd_rdy` handshake. It also serialises single response bytes offered on `resp_data`/`send_resp`, acknowledging each one with `resp_sent`. It sits between the board RX/TX pins and the digital core's command and response ports.

## Interface
- `BAUD_DIV`, 868: clocks per bit (100 MHz / 115200). Minimum 8.
- `TIMEOUT_BITS`, 20: idle bit-periods after which a partially assembled command is discarded.
- `clk  in  1`: system clock; all logic on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `RX  in  1`: serial input from host; asynchronous to `clk`.
- `TX  out  1`: serial output to host.
- `cmd  out  24`: assembled command; first byte received goes to [23:16].
- `cmd_rdy  out  1`: `cmd` is valid; held until cleared.
- `clr_cmd_rdy  in  1`: consumer acknowledge; clears `cmd_rdy`.
- `resp_data  in  8`: response byte.
- `send_resp  in  1`: 1-cycle strobe to transmit `resp_data`.
- `resp_sent  out  1`: 1-cycle pulse when the stop bit finishes.
- `tx_busy  out  1`: transmitter is not idle.
- `frm_err  out  1`: 1-cycle pulse when a byte has a bad stop bit.
- `ovr_err  out  1`: 1-cycle pulse when a byte is dropped because `cmd_rdy`=1.

## Operation
- Reset values:
  - `TX`=1; `cmd`=0.
  - `cmd_rdy`, `resp_sent`, `tx_busy`, `frm_err`, `ovr_err` = 0.
  - RX and TX FSMs IDLE; byte index = 0.
- RX path: `RX` passes through a 2-FF synchroniser with reset value 1.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised falling edge.
  - START: sample at BAUD_DIV/2 cycles (integer division). If the sample is 1, it is a false start → IDLE. Otherwise → DATA.
  - DATA: 8 samples, each BAUD_DIV cycles apart, mid-bit, LSB first.
  - STOP: sample once, BAUD_DIV later. If 1, the byte is delivered. If 0, pulse `frm_err`, discard the byte, and leave the byte index unchanged.
  - STOP→IDLE immediately after the sample; no wait for the end of the stop bit.
- Command assembly:
  - Byte index 0/1/2 loads `cmd[23:16]`/`[15:8]`/`[7:0]` respectively.
  - On index 2, set `cmd_rdy` and return the index to 0.
  - While `cmd_rdy`=1, a delivered byte is dropped, `ovr_err` pulses, and `cmd` is unchanged.
  - `cmd` changes only while `cmd_rdy`=0.
- Timeout: an idle counter runs while the index is nonzero and the RX FSM is IDLE. At TIMEOUT_BITS×BAUD_DIV cycles, the index resets to 0 and the partial bytes are discarded. Any start edge resets the counter.
- `clr_cmd_rdy`: `cmd_rdy` falls the next cycle. If `clr_cmd_rdy` coincides with third-byte completion while `cmd_rdy`=0, the set wins.
- TX FSM states: IDLE, START, DATA, STOP.
  - `send_resp` in IDLE latches `resp_data` into a shift register.
  - The frame is the start bit (0), 8 data bits LSB first, then the stop bit (1), each BAUD_DIV cycles.
  - `send_resp` while `tx_busy`=1 is ignored; no queueing.
  - `tx_busy`=1 from the cycle after an accepted `send_resp` until the cycle `resp_sent` pulses, inclusive.
- RX and TX are fully independent; full duplex is required.
- Baud counters are ceil(log2(BAUD_DIV+1)) bits wide. The timeout counter is sized for TIMEOUT_BITS×BAUD_DIV.

## Timing
- TX latency: `send_resp` in cycle 0 → `TX` low in cycle 1.
  - Bit k (start = 0) drives cycles 1+k·BAUD_DIV through (k+1)·BAUD_DIV.
  - `resp_sent` pulses in cycle 1+10·BAUD_DIV, with `TX`=1 and `tx_busy` falling in the same cycle.
  - A new `send_resp` is accepted in that same cycle.
- RX latency: `cmd_rdy` rises 1 cycle after the stop-bit sample of the third byte. That is about 9.5·BAUD_DIV + 3 cycles after that byte's start edge, counting the 2-cycle synchroniser.
- `frm_err` and `ovr_err` pulse 1 cycle after the stop-bit sample.
- Reset mid-frame, RX: the partial byte and command are lost. Reception restarts on the next falling edge. A line held low through reset is not treated as a start until it returns high and falls again.
- Reset mid-frame, TX: `TX` goes high the next cycle and no `resp_sent` is issued.

## Test plan
- BAUD_DIV=16. Host sends 0x01, 0x23, 0x45 → `cmd`=24'h012345, with `cmd_rdy`=1 one cycle after the third stop sample. Pulse `clr_cmd_rdy` → `cmd_rdy`=0 next cycle.
- `send_resp` with `resp_data`=8'hA5 → TX waveform 0,1,0,1,0,0,1,0,1,1, 16 cycles per bit. `resp_sent` pulses at cycle 161. A second `send_resp` at cycle 50 is ignored.
- With `cmd_rdy`=1, send a 4th byte 0x77 → `ovr_err` pulses and `cmd` stays 24'h012345. Clear, then send 0xAA, 0xBB, 0xCC → `cmd`=24'hAABBCC.
- Send 0x10 with the stop bit forced to 0 → `frm_err` pulses. Then send 0x11, 0x22, 0x33 → `cmd`=24'h112233.
- Send 0x10, 0x20, then idle 20×16+10 cycles, then send 0x30, 0x40, 0x50 → `cmd`=24'h304050. Also a 4-cycle RX low glitch → no byte.
- Full duplex: receive 3 bytes while transmitting 0x3C → both complete correctly. Assert `rst` mid-TX → `TX`=1 next cycle, no `resp_sent`.

Source files
------------

// File: rtl/uart_comm.sv
// uart_comm: host-side 8N1 UART endpoint for the oscilloscope digital core.
// Receives bytes on RX and packs each group of three into a 24-bit command
// (first byte in [23:16]). Transmits single response bytes on TX.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   RX / TX              serial line from / to the host (RX is asynchronous)
//   cmd, cmd_rdy         assembled command, held valid until clr_cmd_rdy
//   clr_cmd_rdy          consumer acknowledge
//   resp_data, send_resp response byte and its one-cycle send strobe
//   resp_sent, tx_busy   end-of-stop-bit pulse, transmitter-active flag
//   frm_err, ovr_err     bad-stop-bit pulse, byte-dropped-while-full pulse
module uart_comm #(
  parameter int unsigned BAUD_DIV     = 868,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp_data,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        tx_busy,
  output logic        frm_err,
  output logic        ovr_err
);

  localparam int unsigned BW     = $clog2(BAUD_DIV + 1);
  localparam int unsigned TO_CYC = TIMEOUT_BITS * BAUD_DIV;
  localparam int unsigned TW     = $clog2(TO_CYC + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------------------------------------------------------- RX sync
  logic       r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0] r_rx_arm;
  logic       w_rx_fall;

  // The edge detector is held off until the synchroniser carries real line
  // data, so a line held low through reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b0;
      r_rx_arm  <= 2'b00;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_arm  <= {r_rx_arm[0], 1'b1};
      r_rx_prev <= r_rx_arm[1] ? r_rx_sync : 1'b0;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // ---------------------------------------------------------------- RX FSM
  state_t          r_rx_state, w_rx_nxt;
  logic [BW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic            w_rx_cnt_clr, w_rx_sample, w_rx_stop_ok, w_rx_stop_bad;

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= S_IDLE;
    else     r_rx_state <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt      = r_rx_state;
    w_rx_cnt_clr  = 1'b0;
    w_rx_sample   = 1'b0;
    w_rx_stop_ok  = 1'b0;
    w_rx_stop_bad = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        if (w_rx_fall) begin
          w_rx_nxt     = S_START;
          w_rx_cnt_clr = 1'b1;
        end
      end
      S_START: begin
        // Mid start bit: a high line here means the edge was a glitch.
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_clr = 1'b1;
          w_rx_nxt     = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == BAUD_LAST) begin
          w_rx_cnt_clr = 1'b1;
          w_rx_sample  = 1'b1;
          if (r_rx_bit == 3'd7) w_rx_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == BAUD_LAST) begin
          w_rx_cnt_clr  = 1'b1;
          w_rx_nxt      = S_IDLE;
          w_rx_stop_ok  = r_rx_sync;
          w_rx_stop_bad = ~r_rx_sync;
        end
      end
      default: w_rx_nxt = S_IDLE;
    endcase
  end

  // RX bit timing and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      if (w_rx_cnt_clr || r_rx_state == S_IDLE) r_rx_cnt <= '0;
      else                                      r_rx_cnt <= r_rx_cnt + BW'(1);
      if (r_rx_state == S_START) r_rx_bit <= '0;
      if (w_rx_sample) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  // ------------------------------------------------------ command assembly
  logic [23:0]   r_cmd;
  logic          r_cmd_rdy, r_frm_err, r_ovr_err;
  logic [1:0]    r_idx;
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
      r_idx     <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_frm_err <= w_rx_stop_bad;
      r_ovr_err <= w_rx_stop_ok & r_cmd_rdy;
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      // Placed after the clear so completion of a command wins over it.
      if (w_rx_stop_ok && !r_cmd_rdy) begin
        case (r_idx)
          2'd0:    r_cmd[23:16] <= r_rx_shift;
          2'd1:    r_cmd[15:8]  <= r_rx_shift;
          default: r_cmd[7:0]   <= r_rx_shift;
        endcase
        if (r_idx == 2'd2) begin
          r_cmd_rdy <= 1'b1;
          r_idx     <= '0;
        end else begin
          r_idx <= r_idx + 2'd1;
        end
      end
      // Idle timeout only runs in RX IDLE, so it never collides with delivery.
      if (r_rx_state != S_IDLE || r_idx == 2'd0 || w_rx_fall) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == TO_LAST) begin
        r_to_cnt <= '0;
        r_idx    <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_t        r_tx_state, w_tx_nxt;
  logic [BW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          r_tx, r_tx_busy, r_resp_sent;
  logic          w_tx_accept, w_tx_bit_end, w_tx_done;

  always_ff @(posedge clk) begin
    if (rst) r_tx_state <= S_IDLE;
    else     r_tx_state <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt     = r_tx_state;
    w_tx_accept  = 1'b0;
    w_tx_done    = 1'b0;
    w_tx_bit_end = (r_tx_cnt == BAUD_LAST);
    case (r_tx_state)
      S_IDLE: begin
        if (send_resp) begin
          w_tx_accept = 1'b1;
          w_tx_nxt    = S_START;
        end
      end
      S_START: if (w_tx_bit_end) w_tx_nxt = S_DATA;
      S_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_nxt = S_STOP;
      S_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_nxt  = S_IDLE;
          w_tx_done = 1'b1;
        end
      end
      default: w_tx_nxt = S_IDLE;
    endcase
  end

  // TX line, shift register and status; busy spans the resp_sent cycle too
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx        <= 1'b1;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_tx_busy   <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_resp_sent <= w_tx_done;
      r_tx_busy   <= w_tx_accept | w_tx_done | (w_tx_nxt != S_IDLE);
      if (w_tx_accept || w_tx_bit_end || r_tx_state == S_IDLE) r_tx_cnt <= '0;
      else                                                     r_tx_cnt <= r_tx_cnt + BW'(1);
      if (w_tx_accept) begin
        r_tx_shift <= resp_data;
        r_tx       <= 1'b0;
        r_tx_bit   <= '0;
      end else if (w_tx_bit_end) begin
        case (r_tx_state)
          S_START: begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end
          S_DATA: begin
            if (r_tx_bit == 3'd7) begin
              r_tx <= 1'b1;
            end else begin
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
              r_tx_bit   <= r_tx_bit + 3'd1;
            end
          end
          default: r_tx <= 1'b1;
        endcase
      end
    end
  end

  assign TX        = r_tx;
  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign resp_sent = r_resp_sent;
  assign tx_busy   = r_tx_busy;
  assign frm_err   = r_frm_err;
  assign ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_uart_comm.sv
// Bench for uart_comm with BAUD_DIV=16: table of received bytes with expected
// command state, TX frame checks against an ideal bit-period waveform, idle
// timeout, glitch rejection, randomized full-duplex rounds and reset cases.
module tb_uart_comm;

  localparam int B  = 16;
  localparam int TB = 20;

  logic        clk = 1'b0;
  logic        rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp;
  logic        resp_sent, tx_busy, frm_err, ovr_err;
  logic [23:0] cmd;
  logic [7:0]  resp_data;

  int checks = 0;
  int errors = 0;
  int frm_n = 0, ovr_n = 0, sent_n = 0;

  uart_comm #(.BAUD_DIV(B), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output, sampled away from the rising edge.
  always @(negedge clk) begin
    if (frm_err)   frm_n++;
    if (ovr_err)   ovr_n++;
    if (resp_sent) sent_n++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host-side 8N1 byte with selectable stop-bit level, then a short idle.
  task automatic rx_byte(input logic [7:0] d, input logic stop);
    RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (B) tick();
    end
    RX = stop;
    repeat (B) tick();
    RX = 1'b1;
    repeat (4) tick();
  endtask

  task automatic clear_rdy();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
  endtask

  // Ideal frame: cycle c (1-based after the accepting cycle) carries bit (c-1)/B.
  // Optional ignored strobe at cycle 50 and back-to-back chaining at 10B+1.
  task automatic tx_frame(input logic [7:0] d, input logic started, input logic ign50,
                          input logic chain, input logic [7:0] nxt);
    logic [9:0] frame;
    frame = {1'b1, d, 1'b0};
    if (!started) begin
      resp_data = d;
      send_resp = 1'b1;
      tick();
    end
    send_resp = 1'b0;
    for (int c = 1; c <= 10 * B + 2; c++) begin
      if (c <= 10 * B) chk("tx_line", 32'(TX), 32'(frame[(c - 1) / B]));
      else             chk("tx_idle_line", 32'(TX), 32'd1);
      chk("resp_sent", 32'(resp_sent), 32'(c == 10 * B + 1));
      chk("tx_busy", 32'(tx_busy), 32'(c <= 10 * B + 1));
      send_resp = 1'b0;
      if (ign50 && c == 50) begin
        resp_data = ~d;
        send_resp = 1'b1;
      end
      if (chain && c == 10 * B + 1) begin
        resp_data = nxt;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        return;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic        clr;
    int          frm;
    int          ovr;
    logic        rdy;
    logic [23:0] cmd;
  } rx_vec_t;

  rx_vec_t vecs[11];

  initial begin
    int fs, os, ss;
    logic [7:0] b0, b1, b2, tb;

    vecs[0]  = '{8'h01, 1'b1, 1'b0, 0, 0, 1'b0, 24'h010000};
    vecs[1]  = '{8'h23, 1'b1, 1'b0, 0, 0, 1'b0, 24'h012300};
    vecs[2]  = '{8'h45, 1'b1, 1'b0, 0, 0, 1'b1, 24'h012345};
    vecs[3]  = '{8'h77, 1'b1, 1'b0, 0, 1, 1'b1, 24'h012345};
    vecs[4]  = '{8'hAA, 1'b1, 1'b1, 0, 0, 1'b0, 24'hAA2345};
    vecs[5]  = '{8'hBB, 1'b1, 1'b0, 0, 0, 1'b0, 24'hAABB45};
    vecs[6]  = '{8'hCC, 1'b1, 1'b0, 0, 0, 1'b1, 24'hAABBCC};
    vecs[7]  = '{8'h10, 1'b0, 1'b1, 1, 0, 1'b0, 24'hAABBCC};
    vecs[8]  = '{8'h11, 1'b1, 1'b0, 0, 0, 1'b0, 24'h11BBCC};
    vecs[9]  = '{8'h22, 1'b1, 1'b0, 0, 0, 1'b0, 24'h1122CC};
    vecs[10] = '{8'h33, 1'b1, 1'b0, 0, 0, 1'b1, 24'h112233};

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp_data = 8'h00;
    repeat (3) tick();
    chk("rst_TX", 32'(TX), 32'd1);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_resp_sent", 32'(resp_sent), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_frm_err", 32'(frm_err), 32'd0);
    chk("rst_ovr_err", 32'(ovr_err), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Table: byte-by-byte command assembly, overrun and framing error.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].clr) clear_rdy();
      fs = frm_n; os = ovr_n;
      rx_byte(vecs[i].data, vecs[i].stop);
      chk($sformatf("vec%0d_frm", i), 32'(frm_n - fs), 32'(vecs[i].frm));
      chk($sformatf("vec%0d_ovr", i), 32'(ovr_n - os), 32'(vecs[i].ovr));
      chk($sformatf("vec%0d_rdy", i), 32'(cmd_rdy), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(vecs[i].cmd));
    end

    // TX: A5 with an ignored mid-frame strobe, then a same-cycle follow-on.
    ss = sent_n;
    tx_frame(8'hA5, 1'b0, 1'b1, 1'b1, 8'h5A);
    tx_frame(8'h5A, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("tx_sent_count", 32'(sent_n - ss), 32'd2);

    // Idle timeout drops a partial command; a short glitch is not a byte.
    clear_rdy();
    fs = frm_n;
    rx_byte(8'h10, 1'b1);
    rx_byte(8'h20, 1'b1);
    repeat (TB * B + 10) tick();
    RX = 1'b0;
    repeat (4) tick();
    RX = 1'b1;
    repeat (40) tick();
    rx_byte(8'h30, 1'b1);
    rx_byte(8'h40, 1'b1);
    chk("to_rdy_after_two", 32'(cmd_rdy), 32'd0);
    rx_byte(8'h50, 1'b1);
    chk("to_rdy", 32'(cmd_rdy), 32'd1);
    chk("to_cmd", 32'(cmd), 32'h304050);
    chk("to_no_frm", 32'(frm_n - fs), 32'd0);

    // Randomized full duplex: three received bytes against one transmitted.
    for (int r = 0; r < 4; r++) begin
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      tb = (r == 0) ? 8'h3C : 8'($urandom);
      clear_rdy();
      fork
        begin
          rx_byte(b0, 1'b1);
          rx_byte(b1, 1'b1);
          rx_byte(b2, 1'b1);
        end
        tx_frame(tb, 1'b0, 1'b0, 1'b0, 8'h00);
      join
      chk($sformatf("dup%0d_rdy", r), 32'(cmd_rdy), 32'd1);
      chk($sformatf("dup%0d_cmd", r), 32'(cmd), 32'({b0, b1, b2}));
    end

    // Reset mid-TX with RX held low through and after reset.
    clear_rdy();
    resp_data = 8'h3C;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    repeat (40) tick();
    ss = sent_n;
    fs = frm_n;
    rst = 1'b1;
    RX = 1'b0;
    tick();
    chk("mid_rst_TX", 32'(TX), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'd0);
    rst = 1'b0;
    repeat (40) tick();
    RX = 1'b1;
    repeat (160) tick();
    chk("mid_rst_no_sent", 32'(sent_n - ss), 32'd0);
    chk("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    rx_byte(b0, 1'b1);
    rx_byte(b1, 1'b1);
    rx_byte(b2, 1'b1);
    chk("post_rst_rdy", 32'(cmd_rdy), 32'd1);
    chk("post_rst_cmd", 32'(cmd), 32'({b0, b1, b2}));
    chk("post_rst_no_frm", 32'(frm_n - fs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
